// File: rtl/vc_input_buffer_if.sv
`default_nettype none
// ============================================================================
// vc_input_buffer_if : link-side and route-computation-side signals of one
//                      router input port. Revision: 1.0
// ============================================================================
interface vc_input_buffer_if #(
  parameter int FLIT_SIZE = 64
);
  logic                 flit_valid_in;
  logic [FLIT_SIZE-1:0] flit_in;
  logic                 stall;
  logic [FLIT_SIZE-1:0] flit_out;
  logic                 flit_valid_out;
  logic [2:0]           dir_in;
  logic                 credit_valid;
  logic                 credit_vc;
  logic                 overflow_err;

  modport master (
    output flit_valid_in, flit_in, stall,
    input  flit_out, flit_valid_out, dir_in, credit_valid, credit_vc, overflow_err
  );

  modport slave (
    input  flit_valid_in, flit_in, stall,
    output flit_out, flit_valid_out, dir_in, credit_valid, credit_vc, overflow_err
  );
endinterface
`default_nettype wire

// File: rtl/vc_input_buffer.sv
`default_nettype none
// ============================================================================
// vc_input_buffer : two-VC input FIFO stage with wormhole VC arbitration and
//                   credit return. Revision: 1.0
// ============================================================================
module vc_input_buffer #(
  parameter int         FLIT_SIZE    = 64,
  parameter int         HEADER_LEN   = 2,
  parameter int         VC_CLASS_POS = 61,
  parameter int         DEPTH        = 4,
  parameter logic [2:0] PORT_DIR     = 3'd0,
  parameter int         HEAD_FLIT    = 0,
  parameter int         BODY_FLIT    = 1,
  parameter int         TAIL_FLIT    = 2,
  parameter int         SINGLE_FLIT  = 3
) (
  input logic             clk,
  input logic             rst,
  vc_input_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [HEADER_LEN-1:0] T_HEAD   = HEADER_LEN'(HEAD_FLIT);
  localparam logic [HEADER_LEN-1:0] T_BODY   = HEADER_LEN'(BODY_FLIT);
  localparam logic [HEADER_LEN-1:0] T_TAIL   = HEADER_LEN'(TAIL_FLIT);
  localparam logic [HEADER_LEN-1:0] T_SINGLE = HEADER_LEN'(SINGLE_FLIT);
  localparam logic [AW:0]           FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                     state, state_next;
  logic                       lock_vc, lock_vc_next;
  logic                       rr_ptr, rr_ptr_next;
  logic                       cur_in_vc;
  logic [HEADER_LEN-1:0]      in_type, out_type;
  logic                       in_starts_pkt, push_vc;
  logic [1:0]                 push, pop, not_empty, full;
  logic [1:0][FLIT_SIZE-1:0]  head_flit;
  logic                       sel_vc, out_valid, do_pop;
  logic [FLIT_SIZE-1:0]       out_flit;
  logic                       credit_valid_q, credit_vc_q, overflow_q;

  assign in_type       = bus.flit_in[FLIT_SIZE-1 -: HEADER_LEN];
  assign in_starts_pkt = (in_type == T_HEAD) || (in_type == T_SINGLE);
  // Body/tail flits carry no trustworthy VC bit; follow the last head/single.
  assign push_vc       = in_starts_pkt ? bus.flit_in[VC_CLASS_POS] : cur_in_vc;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [FLIT_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          cnt;

    assign full[v]      = (cnt == FULL_CNT);
    assign not_empty[v] = (cnt != '0);
    assign push[v]      = bus.flit_valid_in && (push_vc == 1'(v)) && !full[v];
    assign pop[v]       = do_pop && (sel_vc == 1'(v));
    assign head_flit[v] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[v]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[v])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[v], pop[v]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push[v]) mem[wr_ptr] <= bus.flit_in;
    end
  end

  always_comb begin
    sel_vc = rr_ptr;
    if (state == ST_LOCKED)            sel_vc = lock_vc;
    else if (not_empty == 2'b01)       sel_vc = 1'b0;
    else if (not_empty == 2'b10)       sel_vc = 1'b1;
  end

  assign out_valid = not_empty[sel_vc];
  assign out_flit  = head_flit[sel_vc];
  assign out_type  = out_flit[FLIT_SIZE-1 -: HEADER_LEN];
  assign do_pop    = out_valid && !bus.stall;

  // Stray body/tail at a VC head in IDLE is treated like a single flit.
  always_comb begin
    state_next   = state;
    lock_vc_next = lock_vc;
    rr_ptr_next  = rr_ptr;
    if (do_pop) begin
      if (state == ST_IDLE) begin
        if (out_type == T_HEAD) begin
          state_next   = ST_LOCKED;
          lock_vc_next = sel_vc;
        end else begin
          rr_ptr_next  = ~sel_vc;
        end
      end else if ((out_type == T_TAIL) || (out_type == T_SINGLE)) begin
        state_next  = ST_IDLE;
        rr_ptr_next = ~lock_vc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      lock_vc        <= 1'b0;
      rr_ptr         <= 1'b0;
      cur_in_vc      <= 1'b0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state          <= state_next;
      lock_vc        <= lock_vc_next;
      rr_ptr         <= rr_ptr_next;
      credit_valid_q <= do_pop;
      if (do_pop) credit_vc_q <= sel_vc;
      if (bus.flit_valid_in && in_starts_pkt) cur_in_vc <= push_vc;
      if (bus.flit_valid_in && full[push_vc]) overflow_q <= 1'b1;
    end
  end

  assign bus.flit_out       = out_flit;
  assign bus.flit_valid_out = out_valid;
  assign bus.dir_in         = PORT_DIR;
  assign bus.credit_valid   = credit_valid_q;
  assign bus.credit_vc      = credit_vc_q;
  assign bus.overflow_err   = overflow_q;

  // Unused encoding kept for completeness of the type map.
  logic unused_body;
  assign unused_body = ^T_BODY;
endmodule
`default_nettype wire

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Per-port input stage sitting directly upstream of route computation in each router input port.
- Buffers link flits into two VC-class FIFOs, selected by the flit's VC class bit.
- Arbitrates between the two VCs at packet granularity (wormhole) and presents one flit per cycle to route computation, honouring its stall.
- Returns one credit per dequeued flit to the upstream router, tagged with the VC.

Parameters:
- FLIT_SIZE, 64: flit width in bits.
- HEADER_LEN, 2: width of the type field at bits [FLIT_SIZE-1 : FLIT_SIZE-HEADER_LEN].
- VC_CLASS_POS, 61: bit index of the VC class in head and single flits.
- DEPTH, 4: entries per VC FIFO; must be a power of two and at least 2.
- PORT_DIR, 0: 3-bit direction code of this input port, driven on dir_in.
- HEAD_FLIT / BODY_FLIT / TAIL_FLIT / SINGLE_FLIT, 0/1/2/3: type encodings.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flit_valid_in  in  1  link flit valid.
- flit_in  in  FLIT_SIZE  link flit.
- stall  in  1  route computation cannot accept a flit this cycle.
- flit_out  out  FLIT_SIZE  flit presented to route computation (connects to flit_before_RC).
- flit_valid_out  out  1  flit_out is valid.
- dir_in  out  3  constant PORT_DIR.
- credit_valid  out  1  one-cycle credit pulse to upstream.
- credit_vc  out  1  VC of the returned credit.
- overflow_err  out  1  sticky: a flit arrived at a full VC.

Behaviour:
- Reset (synchronous, rst high at a clk edge) values:
  - Both FIFOs empty; lock cleared; round-robin pointer set to VC0.
  - credit_valid=0, credit_vc=0, overflow_err=0, flit_valid_out=0.
  - Reset mid-packet discards all buffered flits; no credits are issued for them.
- VC steering:
  - Head and single flits are written to VC flit_in[VC_CLASS_POS]; that VC is recorded as cur_in_vc.
  - Body and tail flits are written to cur_in_vc.
- Push rules:
  - A push happens when flit_valid_in=1 and the target VC count < DEPTH.
  - If count == DEPTH, the flit is dropped and overflow_err is set; it stays set until reset.
  - Full is judged on the registered count: a pop on the same VC in the same cycle does not admit the push.
- Latency: a flit pushed at edge N can appear on flit_out in the cycle after edge N (one cycle, first-word-fall-through).
- Output and handshake:
  - flit_out and flit_valid_out are combinational from the head of the selected VC.
  - The transfer (pop) occurs when flit_valid_out=1 and stall=0.
  - While stall=1, flit_out holds the same value.
- Output states:
  - IDLE (no lock). If exactly one VC is non-empty, select it. If both are non-empty, select the round-robin pointer's VC. If none, flit_valid_out=0.
  - LOCKED(v). Output comes only from VC v.
    - If v is empty, flit_valid_out=0 even when the other VC holds data.
    - Popping a tail or single flit returns to IDLE and sets the pointer to the other VC (~v).
  - Popping a head flit in IDLE enters LOCKED(selected VC).
  - Popping a single flit in IDLE stays in IDLE and flips the pointer.
  - A body or tail flit at the VC head while in IDLE (protocol error) is passed as a single; state stays IDLE.
- Credits:
  - Registered: a pop at edge N gives credit_valid=1 with credit_vc = popped VC in the cycle after edge N.
  - Exactly one credit per pop; no credit for dropped flits.
- Counts: each VC count is log2(DEPTH)+1 bits. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous push and pop on the same non-full VC leaves the count unchanged, and data order is preserved.

Test Plan:
- Reset, then send single flit type=3, vc=1, payload 0xA5 with stall=0 -> flit_valid_out=1 one cycle later with flit_out equal to the input; credit_valid=1 with credit_vc=1 the following cycle.
- Send a 4-flit packet (head, 2 bodies, tail) on VC0 while holding stall=1 for 3 cycles -> flit_out is stable and no credits while stalled; after release, 4 pops in order and 4 credits with credit_vc=0.
- Interleaved arrival: VC0 head+body+tail and VC1 head+tail, with the VC1 head arriving first -> output is VC1 whole packet then VC0 whole packet, no interleaving. The pointer ends at VC0's opposite (VC1).
- Lock hold: VC0 head popped, VC0 body arrives 5 cycles late, VC1 single waiting -> flit_valid_out=0 for those cycles and the VC1 single is not emitted until after the VC0 tail.
- Overflow: DEPTH=4, stall=1, push 5 flits to VC0 -> count=4, 5th flit dropped, overflow_err=1. After release, exactly 4 flits and 4 credits.
- Pointer wrap and reset: stream 10 single flits through VC1 with push and pop in the same cycle -> order preserved across wrap. Asserting rst with 2 flits buffered -> next cycle flit_valid_out=0, overflow_err=0, and no credits.
